// File: rtl/graph_color_checker.sv
// graph_color_checker: streams graph edges against a flop-based colour table and counts conflicts.
// Define GCC_FIRST_BAD_EN to record the edge index of the first conflict of each pass.
module graph_color_checker #(
  parameter int N_NODES = 64,
  parameter int COLOR_W = 2,
  parameter int CNT_W   = 16,
  parameter int NODE_W  = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               col_wr_en,
  input  logic [NODE_W-1:0]  col_wr_addr,
  input  logic [COLOR_W-1:0] col_wr_data,
  input  logic               start,
  input  logic               edge_valid,
  output logic               edge_ready,
  input  logic [NODE_W-1:0]  edge_u,
  input  logic [NODE_W-1:0]  edge_v,
  input  logic               edge_last,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   conflict_cnt,
  output logic [CNT_W-1:0]   first_bad_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // One extra bit so the limit itself is representable when N_NODES is a power of two.
  localparam logic [NODE_W:0] NodeLimit = (NODE_W + 1)'(N_NODES);

  logic [1:0]         state_q, state_d;
  logic [COLOR_W-1:0] col_q [N_NODES];
  logic [COLOR_W-1:0] col_u, col_v;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               u_oob, v_oob;
  logic               accept, is_conflict, col_we, start_pass;

  assign accept     = edge_valid && (state_q == CHECK);
  assign start_pass = start && (state_q != CHECK);
  assign col_we     = col_wr_en && (state_q != CHECK);

  assign u_oob = {1'b0, edge_u} >= NodeLimit;
  assign v_oob = {1'b0, edge_v} >= NodeLimit;

  // Asynchronous table read; out-of-range indices read 0 but are flagged separately.
  always_comb begin
    col_u = '0;
    col_v = '0;
    for (int i = 0; i < N_NODES; i++) begin
      if (edge_u == NODE_W'(i)) col_u = col_q[i];
      if (edge_v == NODE_W'(i)) col_v = col_q[i];
    end
  end

  assign is_conflict = u_oob || v_oob || ((edge_u != edge_v) && (col_u == col_v));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = CHECK;
      CHECK:      if (accept && edge_last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (start_pass) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (accept) begin
      idx_d = idx_q + CNT_W'(1);
      if (is_conflict && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) col_q[i] <= '0;
    end else if (col_we) begin
      for (int i = 0; i < N_NODES; i++) begin
        if (col_wr_addr == NODE_W'(i)) col_q[i] <= col_wr_data;
      end
    end
  end

`ifdef GCC_FIRST_BAD_EN
  logic [CNT_W-1:0] first_q;

  // A saturating count never returns to zero, so zero means no conflict yet this pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
    end else if (start_pass) begin
      first_q <= '0;
    end else if (accept && is_conflict && (cnt_q == '0)) begin
      first_q <= idx_q;
    end
  end

  assign first_bad_idx = first_q;
`else
  assign first_bad_idx = '0;
`endif

  assign busy         = (state_q == CHECK);
  assign edge_ready   = busy;
  assign done         = (state_q == DONE);
  assign pass         = done && (cnt_q == '0);
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_graph_color_checker.sv
// Self-checking bench for graph_color_checker: directed cases plus randomized passes vs a model.
module tb_graph_color_checker;

  localparam int N_NODES = 4;
  localparam int COLOR_W = 2;
  localparam int CNT_W   = 2;
  localparam int NODE_W  = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               col_wr_en;
  logic [NODE_W-1:0]  col_wr_addr;
  logic [COLOR_W-1:0] col_wr_data;
  logic               start;
  logic               edge_valid;
  logic               edge_ready;
  logic [NODE_W-1:0]  edge_u;
  logic [NODE_W-1:0]  edge_v;
  logic               edge_last;
  logic               busy;
  logic               done;
  logic               pass;
  logic [CNT_W-1:0]   conflict_cnt;
  logic [CNT_W-1:0]   first_bad_idx;

  graph_color_checker #(
    .N_NODES(N_NODES),
    .COLOR_W(COLOR_W),
    .CNT_W  (CNT_W),
    .NODE_W (NODE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .col_wr_en    (col_wr_en),
    .col_wr_addr  (col_wr_addr),
    .col_wr_data  (col_wr_data),
    .start        (start),
    .edge_valid   (edge_valid),
    .edge_ready   (edge_ready),
    .edge_u       (edge_u),
    .edge_v       (edge_v),
    .edge_last    (edge_last),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .conflict_cnt (conflict_cnt),
    .first_bad_idx(first_bad_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int model_col [N_NODES];
  bit model_busy;
  int eu[$];
  int ev[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit edge_bad(input int u, input int v);
    if (u >= N_NODES || v >= N_NODES) return 1'b1;
    return (u != v) && (model_col[u] == model_col[v]);
  endfunction

  function automatic int sat(input int c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  task automatic add_edge(input int u, input int v);
    eu.push_back(u);
    ev.push_back(v);
  endtask

  task automatic write_col(input int a, input int d);
    col_wr_en   = 1'b1;
    col_wr_addr = NODE_W'(a);
    col_wr_data = COLOR_W'(d);
    @(posedge clk); #1;
    col_wr_en = 1'b0;
    if (!model_busy && a < N_NODES) model_col[a] = d;
  endtask

  task automatic set_cols(input int c0, input int c1, input int c2, input int c3);
    write_col(0, c0);
    write_col(1, c1);
    write_col(2, c2);
    write_col(3, c3);
  endtask

  // Runs one pass over eu/ev; optional random gaps and one write attempted while checking.
  task automatic run_pass(input string tag, input bit gaps, input int wr_addr, input int wr_data);
    int cnt   = 0;
    int first = -1;
    int n     = eu.size();
    int exp_first;
    start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    model_busy = 1'b1;
    chk({tag, " busy"}, busy, 1);
    chk({tag, " done0"}, done, 0);
    chk({tag, " cnt0"}, conflict_cnt, 0);
    if (wr_addr >= 0) write_col(wr_addr, wr_data);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          edge_valid  = 1'b0;
          edge_u      = NODE_W'($urandom_range(0, 7));
          edge_v      = NODE_W'($urandom_range(0, 7));
          start       = 1'($urandom_range(0, 1));
          col_wr_en   = 1'($urandom_range(0, 1));
          col_wr_addr = NODE_W'($urandom_range(0, 7));
          col_wr_data = COLOR_W'($urandom_range(0, 3));
          @(posedge clk); #1;
          chk({tag, " gap cnt"}, conflict_cnt, sat(cnt));
          chk({tag, " gap busy"}, busy, 1);
        end
        start     = 1'b0;
        col_wr_en = 1'b0;
      end
      edge_valid = 1'b1;
      edge_u     = NODE_W'(eu[i]);
      edge_v     = NODE_W'(ev[i]);
      edge_last  = (i == n - 1);
      chk({tag, " ready"}, edge_ready, 1);
      @(posedge clk); #1;
      if (edge_bad(eu[i], ev[i])) begin
        if (first < 0) first = i % (1 << CNT_W);
        cnt++;
      end
      chk({tag, " run cnt"}, conflict_cnt, sat(cnt));
    end
    edge_valid = 1'b0;
    edge_last  = 1'b0;
    model_busy = 1'b0;
`ifdef GCC_FIRST_BAD_EN
    exp_first = (first < 0) ? 0 : first;
`else
    exp_first = 0;
`endif
    chk({tag, " done"}, done, 1);
    chk({tag, " pass"}, pass, (cnt == 0) ? 1 : 0);
    chk({tag, " busy end"}, busy, 0);
    chk({tag, " ready end"}, edge_ready, 0);
    chk({tag, " cnt"}, conflict_cnt, sat(cnt));
    chk({tag, " first"}, first_bad_idx, exp_first);
    eu.delete();
    ev.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " ready"}, edge_ready, 0);
    chk({tag, " cnt"}, conflict_cnt, 0);
    chk({tag, " first"}, first_bad_idx, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    col_wr_en   = 1'b0;
    col_wr_addr = '0;
    col_wr_data = '0;
    start       = 1'b0;
    edge_valid  = 1'b0;
    edge_u      = '0;
    edge_v      = '0;
    edge_last   = 1'b0;
    model_busy  = 1'b0;
    foreach (model_col[i]) model_col[i] = 0;

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle ready", edge_ready, 0);

    // Reset leaves every colour 0, so any distinct in-range pair conflicts.
    add_edge(0, 1);
    run_pass("zero table", 1'b0, -1, 0);

    set_cols(0, 1, 2, 0);
    chk("done ready", edge_ready, 0);
    add_edge(0, 1); add_edge(1, 2); add_edge(2, 3);
    run_pass("proper", 1'b0, -1, 0);

    add_edge(0, 1); add_edge(0, 3); add_edge(2, 2); add_edge(1, 3);
    run_pass("one bad", 1'b0, -1, 0);

    add_edge(0, 5);
    run_pass("out of range", 1'b0, -1, 0);

    // Write to col[0] during CHECK is dropped; the following pass still sees colour 0.
    add_edge(1, 2);
    run_pass("wr in check", 1'b0, 0, 3);
    add_edge(0, 1); add_edge(0, 3);
    run_pass("old colour", 1'b0, -1, 0);

    // Reset mid-pass after two conflicting edges.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge_valid = 1'b1;
      edge_u     = NODE_W'(0);
      edge_v     = NODE_W'(3);
      @(posedge clk); #1;
    end
    chk("pre reset cnt", conflict_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid reset");
    edge_valid = 1'b0;
    foreach (model_col[i]) model_col[i] = 0;
    model_busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post reset");
    set_cols(0, 1, 2, 0);
    add_edge(0, 1); add_edge(1, 2); add_edge(2, 3);
    run_pass("fresh", 1'b0, -1, 0);

    repeat (5) add_edge(0, 3);
    run_pass("saturate", 1'b1, -1, 0);

    for (int p = 0; p < 25; p++) begin
      int ne = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) begin
        write_col($urandom_range(0, 3), $urandom_range(0, 3));
      end
      for (int e = 0; e < ne; e++) begin
        int u = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3);
        int v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3);
        add_edge(u, v);
      end
      run_pass("random", 1'b1, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
